// File: rtl/qam_tx_ctrl_if.sv
// rtl/qam_tx_ctrl_if.sv - symbol, mixer and serial-link signal bundle for qam_tx_ctrl
interface qam_tx_ctrl_if #(
  parameter int SAMPLE_W = 8
);
  logic [1:0]          sym_in;
  logic                sym_valid;
  logic                sym_ready;
  logic [1:0]          sym_out;
  logic                mix_en;
  logic [SAMPLE_W-1:0] sample_in;
  logic                ser_bit;
  logic                ser_valid;
  logic                ser_last;

  modport master (
    output sym_in, sym_valid, sample_in,
    input  sym_ready, sym_out, mix_en, ser_bit, ser_valid, ser_last
  );

  modport slave (
    input  sym_in, sym_valid, sample_in,
    output sym_ready, sym_out, mix_en, ser_bit, ser_valid, ser_last
  );
endinterface

// File: rtl/qam_tx_ctrl.sv
// rtl/qam_tx_ctrl.sv - QAM tx sequencer: mix/symbol strobes, LSB-first framed serializer; optional QAM_TX_UNDERRUN_CNT_EN
module qam_tx_ctrl #(
  parameter int MIX_DIV  = 4,
  parameter int SYM_DIV  = 1000,
  parameter int SAMPLE_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  qam_tx_ctrl_if.slave bus,
  output logic         busy,
`ifdef QAM_TX_UNDERRUN_CNT_EN
  output logic [15:0]  underrun_cnt,
  output logic         underrun
`else
  output logic         underrun
`endif
);
  localparam int MIX_W = $clog2(MIX_DIV);
  localparam int SYM_W = $clog2(SYM_DIV);
  localparam int BIT_W = $clog2(SAMPLE_W);
  localparam logic [MIX_W-1:0] MIX_LAST = MIX_W'(MIX_DIV - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [MIX_W-1:0]    mix_cnt_q, mix_cnt_d;
  logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [1:0]          sym_out_q, sym_out_d;
  logic                mix_en_q, mix_en_d;
  logic                ser_bit_q, ser_bit_d;
  logic                ser_valid_q, ser_valid_d;
  logic                ser_last_q, ser_last_d;
  logic                underrun_q, underrun_d;
  logic                emit;
  logic                ur_evt;
  logic                start_ok;
  logic                sym_ready;

  assign sym_ready = (state_q == S_RUN) && (sym_cnt_q == SYM_LAST);
  assign start_ok  = (state_q == S_IDLE) && start && !stop;

  always_comb begin
    state_d     = state_q;
    mix_cnt_d   = '0;
    sym_cnt_d   = '0;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sym_out_d   = sym_out_q;
    mix_en_d    = 1'b0;
    ser_bit_d   = ser_bit_q;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    underrun_d  = underrun_q;
    emit        = 1'b0;
    ur_evt      = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (start_ok) begin
          state_d    = S_RUN;
          underrun_d = 1'b0;
        end
      end
      S_RUN: begin
        // A stop cuts the strobes at this edge so none appear in the next cycle.
        if (!stop) begin
          mix_cnt_d = (mix_cnt_q == MIX_LAST) ? '0 : mix_cnt_q + 1'b1;
          sym_cnt_d = (sym_cnt_q == SYM_LAST) ? '0 : sym_cnt_q + 1'b1;
          mix_en_d  = (mix_cnt_q == MIX_LAST);
        end
        if (sym_ready) begin
          if (bus.sym_valid) begin
            sym_out_d = bus.sym_in;
          end else begin
            sym_out_d  = 2'b00;
            underrun_d = 1'b1;
            ur_evt     = 1'b1;
          end
        end
        if (stop && (bit_cnt_q == '0)) begin
          state_d = S_IDLE;
        end else begin
          emit = 1'b1;
          // Stopping on the last bit closes the frame now; nothing left to drain.
          if (stop) state_d = (bit_cnt_q == BIT_LAST) ? S_IDLE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        emit = 1'b1;
        if (bit_cnt_q == BIT_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      ser_valid_d = 1'b1;
      ser_last_d  = (bit_cnt_q == BIT_LAST);
      bit_cnt_d   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
      if (bit_cnt_q == '0) begin
        ser_bit_d = bus.sample_in[0];
        shift_d   = bus.sample_in >> 1;
      end else begin
        ser_bit_d = shift_q[0];
        shift_d   = shift_q >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mix_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sym_out_q   <= 2'b00;
      mix_en_q    <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mix_cnt_q   <= mix_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sym_out_q   <= sym_out_d;
      mix_en_q    <= mix_en_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef QAM_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (start_ok) ucnt_d = '0;
    else if (ur_evt && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign bus.sym_ready = sym_ready;
  assign bus.sym_out   = sym_out_q;
  assign bus.mix_en    = mix_en_q;
  assign bus.ser_bit   = ser_bit_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign busy          = (state_q != S_IDLE);
  assign underrun      = underrun_q;
endmodule
